dev_bus_host: RTL

//  Initiator for the single-cycle device bus (req/addr/we/be/wdata -> rvalid/rdata) that our

---
 rtl/dev_bus_host.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dev_bus_host.sv
// dev_bus_host: FIFO-buffered initiator issuing one device-bus transaction at a time.
// Optional WAIT timeout with error response is enabled by defining DEV_BUS_HOST_TIMEOUT_EN.
module dev_bus_host #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          CmdDepth      = 4,
    parameter int unsigned          TimeoutCycles = 16,
    parameter logic [DataWidth-1:0] ErrData       = DataWidth'(32'hDEADBEEF)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_we_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_we_o,
    output logic                 rsp_err_o,
    output logic                 host_req_o,
    output logic [AddrWidth-1:0] host_addr_o,
    output logic                 host_we_o,
    output logic [3:0]           host_be_o,
    output logic [DataWidth-1:0] host_wdata_o,
    input  logic                 host_rvalid_i,
    input  logic [DataWidth-1:0] host_rdata_i,
    output logic                 busy_o
);

    localparam int unsigned CW = AddrWidth + 1 + 4 + DataWidth;
    localparam int unsigned PW = $clog2(CmdDepth);
    localparam int unsigned NW = $clog2(CmdDepth + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_mem [CmdDepth];
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [NW-1:0]          r_count;
    logic [AddrWidth-1:0]   r_host_addr;
    logic                   r_host_we;
    logic [3:0]             r_host_be;
    logic [DataWidth-1:0]   r_host_wdata;
    logic                   r_rsp_valid;
    logic [DataWidth-1:0]   r_rsp_rdata;
    logic                   r_rsp_we;
    logic                   w_full, w_empty, w_push, w_pop, w_rsp_free, w_done, w_timeout;

    assign w_full      = (r_count == NW'(CmdDepth));
    assign w_empty     = (r_count == '0);
    assign w_push      = cmd_valid_i && !w_full;
    // A new transaction may start only if the response slot is free or being freed now
    assign w_rsp_free  = !r_rsp_valid || rsp_ready_i;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && w_rsp_free;
    assign w_done      = (r_state == S_WAIT) && host_rvalid_i;

    assign cmd_ready_o  = !w_full;
    assign host_addr_o  = r_host_addr;
    assign host_we_o    = r_host_we;
    assign host_be_o    = r_host_be;
    assign host_wdata_o = r_host_wdata;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_we_o     = r_rsp_we;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= {cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_host_addr  <= '0;
            r_host_we    <= 1'b0;
            r_host_be    <= '0;
            r_host_wdata <= '0;
        end else if (w_pop) begin
            {r_host_addr, r_host_we, r_host_be, r_host_wdata} <= r_mem[r_rptr];
        end
    end

`ifdef DEV_BUS_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_rsp_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 r_tcnt <= '0;
        else if (r_state == S_REQ)   r_tcnt <= '0;
        else if (r_state == S_WAIT)  r_tcnt <= r_tcnt + TW'(1);
    end

    // rvalid in the final WAIT cycle takes priority over the timeout
    assign w_timeout = (r_state == S_WAIT) && !host_rvalid_i &&
                       (r_tcnt == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_rsp_err <= 1'b0;
        else if (w_done)    r_rsp_err <= 1'b0;
        else if (w_timeout) r_rsp_err <= 1'b1;
    end

    assign rsp_err_o = r_rsp_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TimeoutCycles;
    assign w_timeout        = 1'b0;
    assign rsp_err_o        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_we    <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= host_rdata_i;
            r_rsp_we    <= r_host_we;
        end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ErrData;
            r_rsp_we    <= r_host_we;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        host_req_o = (r_state == S_REQ);
        busy_o     = (r_state != S_IDLE) || !w_empty;
    end

endmodule
